// File: rtl/riscv_pkg.sv
// Shared definitions for the five-stage RISC-V core: datapath width, opcodes,
// ALUOp classes and the decoded control bundle carried down the pipeline.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // A bubble is an instruction whose control bundle cannot change any state.
  localparam ctrl_t BUBBLE = ctrl_t'('0);

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decoder/register-file side inputs and EX side outputs,
// plus the stall/flush requests and hazard/perf feedback.
interface id_ex_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             Stall_i, Flush_i;
  logic             RegWrite_i, MemReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]       ALUOp_i;
  logic [XLEN-1:0]  RS1Data_i, RS2Data_i, Imm_i;
  logic [9:0]       Funct_i;
  logic [4:0]       RS1Addr_i, RS2Addr_i, RdAddr_i;

  logic             RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]       ALUOp_o;
  logic [XLEN-1:0]  RS1Data_o, RS2Data_o, Imm_o;
  logic [9:0]       Funct_o;
  logic [4:0]       RS1Addr_o, RS2Addr_o, RdAddr_o;
  logic             Valid_o, Hazard_o;
  logic [CNT_W-1:0] BubbleCnt_o;

  modport master (
    output Stall_i, Flush_i, RegWrite_i, MemReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
           ALUOp_i, RS1Data_i, RS2Data_i, Imm_i, Funct_i, RS1Addr_i, RS2Addr_i, RdAddr_i,
    input  RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1Data_o, RS2Data_o, Imm_o, Funct_o, RS1Addr_o, RS2Addr_o, RdAddr_o,
           Valid_o, Hazard_o, BubbleCnt_o
  );

  modport slave (
    input  Stall_i, Flush_i, RegWrite_i, MemReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
           ALUOp_i, RS1Data_i, RS2Data_i, Imm_i, Funct_i, RS1Addr_i, RS2Addr_i, RdAddr_i,
    output RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1Data_o, RS2Data_o, Imm_o, Funct_o, RS1Addr_o, RS2Addr_o, RdAddr_o,
           Valid_o, Hazard_o, BubbleCnt_o
  );
endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard: the load now in EX writes a register the ID instruction reads.
module hazard_detect (
  input  logic       valid_i,
  input  logic       mem_read_i,
  input  logic [4:0] rd_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  output logic       hazard_o
);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = valid_i & mem_read_i & (rd_addr_i != 5'd0) &
                    ((rd_addr_i == rs1_addr_i) | (rd_addr_i == rs2_addr_i));
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decoded instruction, inserts bubbles on
// flush or load-use hazard, and counts inserted bubbles (saturating).
module id_ex_reg #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  id_ex_reg_if.slave  bus
);
  import riscv_pkg::*;

  ctrl_t            ctrl_in, ctrl_d, ctrl_q;
  logic [XLEN-1:0]  rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [9:0]       funct_d, funct_q;
  logic [4:0]       rs1_addr_d, rs1_addr_q, rs2_addr_d, rs2_addr_q, rd_addr_d, rd_addr_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hazard, bubble;

  hazard_detect u_hazard (
    .valid_i    (valid_q),
    .mem_read_i (ctrl_q.mem_read),
    .rd_addr_i  (rd_addr_q),
    .rs1_addr_i (bus.RS1Addr_i),
    .rs2_addr_i (bus.RS2Addr_i),
    .hazard_o   (hazard)
  );

  assign ctrl_in = '{reg_write: bus.RegWrite_i, mem_reg: bus.MemReg_i,
                     mem_read:  bus.MemRead_i,  mem_write: bus.MemWrite_i,
                     alu_src:   bus.ALUSrc_i,   alu_op: alu_op_e'(bus.ALUOp_i)};
  assign bubble  = bus.Flush_i | hazard;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (!bus.Stall_i) begin
      ctrl_d     = ctrl_in;
      rs1_data_d = bus.RS1Data_i;
      rs2_data_d = bus.RS2Data_i;
      imm_d      = bus.Imm_i;
      funct_d    = bus.Funct_i;
      rs1_addr_d = bus.RS1Addr_i;
      rs2_addr_d = bus.RS2Addr_i;
      rd_addr_d  = bus.RdAddr_i;
      valid_d    = 1'b1;
      // Flush and hazard in the same cycle still cost exactly one bubble.
      if (bubble) begin
        ctrl_d  = BUBBLE;
        valid_d = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= BUBBLE;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.RegWrite_o  = ctrl_q.reg_write;
  assign bus.MemReg_o    = ctrl_q.mem_reg;
  assign bus.MemRead_o   = ctrl_q.mem_read;
  assign bus.MemWrite_o  = ctrl_q.mem_write;
  assign bus.ALUSrc_o    = ctrl_q.alu_src;
  assign bus.ALUOp_o     = ctrl_q.alu_op;
  assign bus.RS1Data_o   = rs1_data_q;
  assign bus.RS2Data_o   = rs2_data_q;
  assign bus.Imm_o       = imm_q;
  assign bus.Funct_o     = funct_q;
  assign bus.RS1Addr_o   = rs1_addr_q;
  assign bus.RS2Addr_o   = rs2_addr_q;
  assign bus.RdAddr_o    = rd_addr_q;
  assign bus.Valid_o     = valid_q;
  assign bus.Hazard_o    = hazard;
  assign bus.BubbleCnt_o = cnt_q;

endmodule
